// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and constants for the conv layer sequencing blocks
package cnn_pkg;

    // Widest frame any conv layer handles; hcount/vcount buses are sized for it
    localparam int FRAME_W   = 32;
    localparam int CNN_PIX_W = 21;

    typedef logic signed [CNN_PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/seq_delay_pipe.sv
// rtl/seq_delay_pipe.sv - N-deep shift register with synchronous flush
module seq_delay_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clr_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] r_stage [DEPTH];

    // Shift one stage per cycle; a flush empties every stage including the incoming word
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (clr_in) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign q_out = r_stage[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - paces one frame from read BRAM into a conv layer and captures its output
module conv_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PIX_W     = 21,
    parameter int ADDR_W    = 10,
    parameter int ISSUE_GAP = 8,
    parameter int RD_LAT    = 2,
    parameter int DRAIN_CYC = 64
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic                abort_in,
    output logic                busy_out,
    output logic                done_out,
    output logic                rd_en_out,
    output logic [ADDR_W-1:0]   rd_addr_out,
    input  logic [PIX_W-1:0]    rd_data_in,
    output logic                conv_valid_out,
    output logic [PIX_W-1:0]    conv_pixel_out,
    output logic [4:0]          conv_hcount_out,
    output logic [4:0]          conv_vcount_out,
    input  logic                conv_valid_in,
    input  logic [PIX_W-1:0]    conv_pixel_in,
    input  logic [4:0]          conv_hcount_in,
    input  logic [4:0]          conv_vcount_in,
    output logic                wr_en_out,
    output logic [ADDR_W-1:0]   wr_addr_out,
    output logic [PIX_W-1:0]    wr_data_out,
    output logic [ADDR_W:0]     out_count_out
);

    localparam int LOG2W  = $clog2(WIDTH);
    localparam int CNT_W  = $clog2(FRAME_W);
    localparam int GAP_W  = $clog2(ISSUE_GAP);
    localparam int DRN_W  = $clog2(DRAIN_CYC + 1);
    localparam int PIPE_W = 1 + 2 * LOG2W;

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic                w_busy;
    logic                w_done;

    logic [LOG2W-1:0]    r_h;
    logic [LOG2W-1:0]    r_v;
    logic [GAP_W-1:0]    r_gap;
    logic                r_rd_done;
    logic [DRN_W-1:0]    r_drain;

    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [PIX_W-1:0]    r_wr_data;
    logic [ADDR_W:0]     r_out_count;

    logic                w_rd_en;
    logic                w_last_rd;
    logic                w_accept;
    logic [PIPE_W-1:0]   w_pipe_d;
    logic [PIPE_W-1:0]   w_pipe_q;
    logic                w_pv_valid;
    logic [LOG2W-1:0]    w_pv_h;
    logic [LOG2W-1:0]    w_pv_v;
    logic                w_tail_done;

    assign w_rd_en   = (r_state == ISSUE) && (r_gap == '0) && !r_rd_done;
    assign w_last_rd = w_rd_en && (&r_h) && (&r_v);
    assign w_accept  = conv_valid_in && !abort_in && ((r_state == ISSUE) || (r_state == DRAIN));

    // Coordinates ride alongside valid; idle slots carry zeros so the outputs rest at 0
    assign w_pipe_d = w_rd_en ? {1'b1, r_v, r_h} : '0;

    seq_delay_pipe #(
        .DEPTH (RD_LAT),
        .W     (PIPE_W)
    ) u_rd_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr_in (abort_in),
        .d_in   (w_pipe_d),
        .q_out  (w_pipe_q)
    );

    assign w_pv_valid  = w_pipe_q[PIPE_W-1];
    assign w_pv_v      = w_pipe_q[2*LOG2W-1:LOG2W];
    assign w_pv_h      = w_pipe_q[LOG2W-1:0];
    // Only the bottom-right pixel emerges with both coordinates all-ones
    assign w_tail_done = w_pv_valid && (&w_pv_h) && (&w_pv_v);

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state and status decode; abort overrides every transition
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE:  if (start_in) w_next = ISSUE;
            ISSUE: begin
                w_busy = 1'b1;
                if (w_tail_done) w_next = DRAIN;
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (!conv_valid_in && (r_drain == DRN_W'(1))) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (abort_in) w_next = IDLE;
    end

    // Raster position and issue pacing; held cleared outside ISSUE
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_h       <= '0;
            r_v       <= '0;
            r_gap     <= '0;
            r_rd_done <= 1'b0;
        end else if (abort_in || (r_state != ISSUE)) begin
            r_h       <= '0;
            r_v       <= '0;
            r_gap     <= '0;
            r_rd_done <= 1'b0;
        end else if (w_rd_en) begin
            r_gap <= GAP_W'(ISSUE_GAP - 1);
            r_h   <= r_h + 1'b1;
            if (&r_h) r_v <= r_v + 1'b1;
            if (w_last_rd) r_rd_done <= 1'b1;
        end else if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
        end
    end

    // Drain timer: armed during ISSUE, re-armed by each layer output, counts idle cycles
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_drain <= '0;
        end else if (r_state == ISSUE) begin
            r_drain <= DRN_W'(DRAIN_CYC);
        end else if (r_state == DRAIN) begin
            if (conv_valid_in)        r_drain <= DRN_W'(DRAIN_CYC);
            else if (r_drain != '0)   r_drain <= r_drain - 1'b1;
        end else begin
            r_drain <= '0;
        end
    end

    // Registered capture of layer outputs into the write BRAM
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= w_accept;
            r_wr_addr <= w_accept ? {conv_vcount_in[LOG2W-1:0], conv_hcount_in[LOG2W-1:0]} : '0;
            r_wr_data <= w_accept ? conv_pixel_in : '0;
        end
    end

    // Output tally: cleared by an accepted start, otherwise held so software can read it after done
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_out_count <= '0;
        end else if ((r_state == IDLE) && start_in && !abort_in) begin
            r_out_count <= '0;
        end else if (w_accept && (r_out_count != '1)) begin
            r_out_count <= r_out_count + 1'b1;
        end
    end

    // Zero-extend the frame coordinates onto the fixed-width count buses
    always_comb begin
        conv_hcount_out = '0;
        conv_vcount_out = '0;
        conv_hcount_out[LOG2W-1:0] = w_pv_h;
        conv_vcount_out[LOG2W-1:0] = w_pv_v;
    end

    assign busy_out       = w_busy;
    assign done_out       = w_done;
    assign rd_en_out      = w_rd_en;
    assign rd_addr_out    = w_rd_en ? {r_v, r_h} : '0;
    assign conv_valid_out = w_pv_valid;
    assign conv_pixel_out = w_pv_valid ? rd_data_in : '0;
    assign wr_en_out      = r_wr_en;
    assign wr_addr_out    = r_wr_addr;
    assign wr_data_out    = r_wr_data;
    assign out_count_out  = r_out_count;

    localparam int UNUSED_CNT_W = CNT_W;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - self-checking bench for conv_frame_sequencer
module tb_conv_frame_sequencer;
    import cnn_pkg::*;

    localparam int W   = 4;
    localparam int PW  = 21;
    localparam int AW  = 4;
    localparam int GAP = 3;
    localparam int LAT = 2;
    localparam int DRN = 20;
    localparam int NPIX = W * W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_in = 1'b0;
    logic           abort_in = 1'b0;
    logic           busy_out, done_out, rd_en_out;
    logic [AW-1:0]  rd_addr_out;
    logic [PW-1:0]  rd_data_in;
    logic           conv_valid_out;
    logic [PW-1:0]  conv_pixel_out;
    logic [4:0]     conv_hcount_out, conv_vcount_out;
    logic           conv_valid_in;
    logic [PW-1:0]  conv_pixel_in;
    logic [4:0]     conv_hcount_in, conv_vcount_in;
    logic           wr_en_out;
    logic [AW-1:0]  wr_addr_out;
    logic [PW-1:0]  wr_data_out;
    logic [AW:0]    out_count_out;

    conv_frame_sequencer #(
        .WIDTH(W), .PIX_W(PW), .ADDR_W(AW), .ISSUE_GAP(GAP), .RD_LAT(LAT), .DRAIN_CYC(DRN)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_in), .abort_in(abort_in),
        .busy_out(busy_out), .done_out(done_out),
        .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
        .conv_valid_out(conv_valid_out), .conv_pixel_out(conv_pixel_out),
        .conv_hcount_out(conv_hcount_out), .conv_vcount_out(conv_vcount_out),
        .conv_valid_in(conv_valid_in), .conv_pixel_in(conv_pixel_in),
        .conv_hcount_in(conv_hcount_in), .conv_vcount_in(conv_vcount_in),
        .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
        .out_count_out(out_count_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Read BRAM: data for an address shows up two cycles after its enable
    pixel_t        mem [NPIX];
    logic [AW-1:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        if (rd_en_out) d1 <= rd_addr_out;
        d2 <= d1;
    end
    assign rd_data_in = mem[d2];

    // Layer stand-in: mode 0 loops pixels back shifted by 2 for h,v >= 2; mode 1 plays a driven burst
    int          mode = 0;
    logic        bv = 1'b0;
    logic [4:0]  bh = '0, bvc = '0;
    pixel_t      bp = '0;
    assign conv_valid_in  = (mode == 1) ? bv : (conv_valid_out && conv_hcount_out >= 5'd2 && conv_vcount_out >= 5'd2);
    assign conv_pixel_in  = (mode == 1) ? bp : conv_pixel_out;
    assign conv_hcount_in = (mode == 1) ? bh : conv_hcount_out - 5'd2;
    assign conv_vcount_in = (mode == 1) ? bvc : conv_vcount_out - 5'd2;

    // Event logs sampled on the falling edge
    int     rd_t[$], rd_a[$], cv_t[$], cv_h[$], cv_v[$], wr_t[$], wr_a[$], done_t[$], bfall_t[$];
    pixel_t cv_p[$], wr_d[$];
    int     eb_a[$];
    pixel_t eb_d[$];
    logic   prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rd_en_out) begin rd_t.push_back(cyc); rd_a.push_back(int'(rd_addr_out)); end
        if (conv_valid_out) begin
            cv_t.push_back(cyc); cv_p.push_back(pixel_t'(conv_pixel_out));
            cv_h.push_back(int'(conv_hcount_out)); cv_v.push_back(int'(conv_vcount_out));
        end
        if (wr_en_out) begin wr_t.push_back(cyc); wr_a.push_back(int'(wr_addr_out)); wr_d.push_back(pixel_t'(wr_data_out)); end
        if (done_out) done_t.push_back(cyc);
        if (prev_busy && !busy_out) bfall_t.push_back(cyc);
        prev_busy = busy_out;
    end

    int n_chk = 0;
    int n_fail = 0;
    int start_t = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, longint'({busy_out, done_out, rd_en_out, conv_valid_out, wr_en_out}), 0);
        check({name, "_rdaddr"}, longint'(rd_addr_out), 0);
        check({name, "_cpix"}, longint'(conv_pixel_out), 0);
        check({name, "_chv"}, longint'({conv_hcount_out, conv_vcount_out}), 0);
        check({name, "_wr"}, longint'({wr_addr_out, wr_data_out}), 0);
        check({name, "_cnt"}, longint'(out_count_out), 0);
    endtask

    task automatic clear_logs();
        rd_t.delete(); rd_a.delete(); cv_t.delete(); cv_h.delete(); cv_v.delete(); cv_p.delete();
        wr_t.delete(); wr_a.delete(); wr_d.delete(); done_t.delete(); bfall_t.delete();
        eb_a.delete(); eb_d.delete();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = pixel_t'($urandom);
    endtask

    task automatic run_frame(input int md, input int abort_at, input bit restarts);
        int  nrd = 0, bcnt = 0, since = 0;
        bit  aborted = 0, finished = 0;
        clear_logs();
        mode = md;
        @(posedge clk); #2;
        start_in = 1'b1;
        start_t  = cyc;
        @(posedge clk); #2;
        for (int k = 0; k < 3000; k++) begin
            start_in = 1'b0; abort_in = 1'b0; bv = 1'b0;
            if (aborted) since++;
            if (done_t.size() > 0 || (aborted && since >= 40)) begin finished = 1; break; end
            if (rd_en_out) nrd++;
            if (abort_at != 0 && nrd == abort_at && !aborted) begin abort_in = 1'b1; aborted = 1; end
            if (restarts && $urandom_range(0, 5) == 0) start_in = 1'b1;
            if (md == 1 && cv_t.size() == NPIX && bcnt < 10 && cyc >= cv_t[NPIX-1] + 5) begin
                bv  = 1'b1;
                bh  = 5'($urandom_range(0, 31));
                bvc = 5'($urandom_range(0, 31));
                bp  = pixel_t'($urandom);
                eb_a.push_back((int'(bvc) % W) * W + int'(bh) % W);
                eb_d.push_back(bp);
                bcnt++;
            end
            @(posedge clk); #2;
        end
        start_in = 1'b0; abort_in = 1'b0; bv = 1'b0;
        if (!finished) check("frame_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic check_frame(input string tag, input int md, input int abort_at);
        int     nexp_rd = (abort_at != 0) ? abort_at : NPIX;
        int     nexp_cv = (abort_at != 0) ? abort_at - 1 : NPIX;
        int     ea[$];
        pixel_t ed[$];
        check({tag, "_rd_cnt"}, rd_t.size(), nexp_rd);
        for (int i = 0; i < rd_t.size() && i < nexp_rd; i++) begin
            check($sformatf("%s_rd_addr%0d", tag, i), rd_a[i], i);
            check($sformatf("%s_rd_time%0d", tag, i), rd_t[i], start_t + 1 + i * GAP);
        end
        check({tag, "_cv_cnt"}, cv_t.size(), nexp_cv);
        for (int i = 0; i < cv_t.size() && i < nexp_cv; i++) begin
            check($sformatf("%s_cv_time%0d", tag, i), cv_t[i], start_t + 1 + i * GAP + LAT);
            check($sformatf("%s_cv_pix%0d", tag, i), cv_p[i], mem[i]);
            check($sformatf("%s_cv_h%0d", tag, i), cv_h[i], i % W);
            check($sformatf("%s_cv_v%0d", tag, i), cv_v[i], i / W);
        end
        if (abort_at != 0) begin
            check({tag, "_done_cnt"}, done_t.size(), 0);
            check({tag, "_busy_end"}, busy_out, 0);
            check({tag, "_cnt_held"}, out_count_out, wr_t.size());
            return;
        end
        if (md == 0) begin
            for (int a = 0; a < NPIX; a++)
                if (a % W >= 2 && a / W >= 2) begin
                    ea.push_back((a / W - 2) * W + (a % W - 2));
                    ed.push_back(mem[a]);
                end
        end else begin
            ea = eb_a;
            ed = eb_d;
        end
        check({tag, "_wr_cnt"}, wr_t.size(), ea.size());
        for (int i = 0; i < wr_t.size() && i < ea.size(); i++) begin
            check($sformatf("%s_wr_addr%0d", tag, i), wr_a[i], ea[i]);
            check($sformatf("%s_wr_data%0d", tag, i), wr_d[i], ed[i]);
        end
        check({tag, "_out_count"}, out_count_out, ea.size());
        check({tag, "_done_cnt"}, done_t.size(), 1);
        if (done_t.size() > 0 && wr_t.size() > 0)
            check({tag, "_done_gap"}, done_t[0] - wr_t[wr_t.size()-1], DRN);
        if (done_t.size() > 0)
            check({tag, "_busy_fall"}, (bfall_t.size() > 0) ? bfall_t[0] : -1, done_t[0]);
    endtask

    typedef struct {
        logic start;
        logic abort;
        logic busy;
        logic rd_en;
        logic cvalid;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        fill_mem();

        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #2;
        check_zero("idle");

        for (int i = 0; i < 7; i++) begin
            start_in = vecs[i].start;
            abort_in = vecs[i].abort;
            @(posedge clk); #1;
            check($sformatf("vec%0d_busy", i), busy_out, vecs[i].busy);
            check($sformatf("vec%0d_rd_en", i), rd_en_out, vecs[i].rd_en);
            check($sformatf("vec%0d_cvalid", i), conv_valid_out, vecs[i].cvalid);
            check($sformatf("vec%0d_done", i), done_out, 0);
            #1;
        end
        start_in = 1'b0;
        abort_in = 1'b0;

        fill_mem();
        run_frame(0, 0, 1'b1);
        check_frame("loop", 0, 0);

        fill_mem();
        run_frame(1, 0, 1'b0);
        check_frame("burst", 1, 0);

        fill_mem();
        run_frame(0, 7, 1'b0);
        check_frame("abort", 0, 7);

        fill_mem();
        clear_logs();
        mode = 0;
        @(posedge clk); #2;
        start_in = 1'b1;
        @(posedge clk); #2;
        start_in = 1'b0;
        for (int k = 0; k < 200 && rd_t.size() < 3; k++) @(posedge clk);
        check("rst_wait_reads", rd_t.size(), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        fill_mem();
        run_frame(0, 0, 1'b0);
        check_frame("postrst", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
